// File: rtl/mod_counter_chain.sv
// Cascade of up/down modulo counters with per-stage load,
// ripple carry/borrow, optional saturation and a registered wrap pulse.
module mod_counter_chain #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned W = 6,
  parameter logic [8*STAGES-1:0] MODS = {8'd24, 8'd60, 8'd60},
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  updown,
  input  logic                  load,
  input  logic [STAGES-1:0]     load_sel,
  input  logic [W-1:0]          load_val,
  output logic [STAGES*W-1:0]   count,
  output logic [STAGES-1:0]     stage_tc,
  output logic                  wrap
);

  logic [STAGES-1:0] carry;
  logic [STAGES-1:0] ldd;
  logic              limit;

  assign limit = enable & (&stage_tc);
  assign carry[0] = enable;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    localparam int unsigned MOD = int'(MODS[8*i+7:8*i]);
    localparam logic [W:0] TOP = (W+1)'(MOD - 1);

    logic [W-1:0] val;
    logic [W-1:0] nxt;
    logic [W-1:0] ld_v;
    logic         tc_up;
    logic         tc_dn;
    logic         adv;

    // out-of-range values count as terminal in both directions
    assign tc_up = {1'b0, val} >= TOP;
    assign tc_dn = (val == '0) || ({1'b0, val} > TOP);
    assign stage_tc[i] = updown ? tc_up : tc_dn;

    assign ldd[i] = load & load_sel[i];
    assign ld_v = ({1'b0, load_val} > TOP) ? TOP[W-1:0] : load_val;

    always_comb begin
      nxt = val;
      if (updown) nxt = tc_up ? '0 : val + 1'b1;
      else        nxt = tc_dn ? TOP[W-1:0] : val - 1'b1;
    end

    assign adv = carry[i] & ~ldd[i] & ~(SATURATE & limit);

    // a loaded stage swallows the carry/borrow
    if (i < STAGES - 1) begin : g_carry
      assign carry[i+1] = carry[i] & stage_tc[i] & ~ldd[i];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset)       val <= '0;
      else if (ldd[i]) val <= ld_v;
      else if (adv)    val <= nxt;
    end

    assign count[W*i +: W] = val;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wrap <= 1'b0;
    else       wrap <= !SATURATE && limit && !load;
  end

endmodule
